// File: rtl/load_pkg.sv
// Shared types and instruction-field layout for the load block.
package load_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } load_state_t;

    localparam int LP_DRAM_ADDR_LSB = 96;
    localparam int LP_DRAM_ADDR_W   = 32;
    localparam int LP_BYTES_LSB     = 80;
    localparam int LP_BYTES_W       = 16;
    localparam int LP_LINES_LSB     = 48;
    localparam int LP_LINES_W       = 16;
    localparam int LP_START_LSB     = 32;
    localparam int LP_GRP_LSB       = 0;
    localparam int LP_GRP_W         = 6;

    localparam logic [LP_GRP_W-1:0] GRP_1A = 6'b000001;
    localparam logic [LP_GRP_W-1:0] GRP_2A = 6'b000010;
    localparam logic [LP_GRP_W-1:0] GRP_1B = 6'b000100;
    localparam logic [LP_GRP_W-1:0] GRP_2B = 6'b001000;

    localparam int LP_BUF_DEPTH = 2048;

endpackage

// File: rtl/load_group_demux.sv
// Fans the single registered line write out to the four feature-buffer ports
// according to the latched one-hot group; unknown groups enable nothing.
module load_group_demux
    import load_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 512
)(
    input  logic                i_wvalid,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [LP_GRP_W-1:0] i_group,
    output logic                o_wvalid_1a,
    output logic [ADDR_W-1:0]   o_waddr_1a,
    output logic [DATA_W-1:0]   o_wdata_1a,
    output logic                o_wvalid_2a,
    output logic [ADDR_W-1:0]   o_waddr_2a,
    output logic [DATA_W-1:0]   o_wdata_2a,
    output logic                o_wvalid_1b,
    output logic [ADDR_W-1:0]   o_waddr_1b,
    output logic [DATA_W-1:0]   o_wdata_1b,
    output logic                o_wvalid_2b,
    output logic [ADDR_W-1:0]   o_waddr_2b,
    output logic [DATA_W-1:0]   o_wdata_2b
);

    assign o_wvalid_1a = i_wvalid && (i_group == GRP_1A);
    assign o_wvalid_2a = i_wvalid && (i_group == GRP_2A);
    assign o_wvalid_1b = i_wvalid && (i_group == GRP_1B);
    assign o_wvalid_2b = i_wvalid && (i_group == GRP_2B);

    // Address/data registers only move on a write, so each bus holds its last
    // written value between writes without per-buffer storage.
    assign o_waddr_1a = i_waddr;
    assign o_wdata_1a = i_wdata;
    assign o_waddr_2a = i_waddr;
    assign o_wdata_2a = i_wdata;
    assign o_waddr_1b = i_waddr;
    assign o_wdata_1b = i_wdata;
    assign o_waddr_2b = i_waddr;
    assign o_wdata_2b = i_wdata;

endmodule

// File: rtl/load.sv
// Load engine: decodes a load instruction, launches one AXI read and writes the
// returned beats into the selected feature buffer. Optional LOAD_LEN_CHECK_EN adds err_len_mismatch.
module load
    import load_pkg::*;
#(
    parameter int LOAD_INST_LENGTH   = 128,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BUF_ADDR_WIDTH   = 11
)(
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ap_start,
    output logic                          ap_done,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [LOAD_INST_LENGTH-1:0]   ctrl_instruction,
    output logic                          rd_ctrl_start,
    input  logic                          rd_ctrl_done,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] rd_ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]  rd_ctrl_xfer_size_in_bytes,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] s_axis_tdata,
    output logic                          load_write_buffer_1_A_wvalid,
    output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_1_A_waddr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_1_A_wdata,
    output logic                          load_write_buffer_2_A_wvalid,
    output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_2_A_waddr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_2_A_wdata,
    output logic                          load_write_buffer_1_B_wvalid,
    output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_1_B_waddr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_1_B_wdata,
    output logic                          load_write_buffer_2_B_wvalid,
    output logic [C_BUF_ADDR_WIDTH-1:0]   load_write_buffer_2_B_waddr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] load_write_buffer_2_B_wdata
`ifdef LOAD_LEN_CHECK_EN
    ,
    output logic                          err_len_mismatch
`endif
);

    load_state_t                   r_state;
    load_state_t                   w_state_nxt;

    logic [C_M_AXI_ADDR_WIDTH-1:0] r_rd_addr;
    logic [C_XFER_SIZE_WIDTH-1:0]  r_xfer_size;
    logic [LP_LINES_W-1:0]         r_lines_left;
    logic [C_BUF_ADDR_WIDTH-1:0]   r_cur_addr;
    logic [LP_GRP_W-1:0]           r_group;
    logic                          r_rd_done;

    logic                          r_wvalid;
    logic [C_BUF_ADDR_WIDTH-1:0]   r_waddr;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;

    logic [LP_DRAM_ADDR_W-1:0]     w_inst_dram;
    logic [LP_BYTES_W-1:0]         w_inst_bytes;
    logic [LP_LINES_W-1:0]         w_inst_lines;
    logic [C_BUF_ADDR_WIDTH-1:0]   w_inst_start;
    logic [LP_GRP_W-1:0]           w_inst_group;
    logic                          w_unused_inst;

    logic                          w_start_acc;
    logic                          w_beat_acc;
    logic                          w_beat_write;

    assign w_inst_dram  = ctrl_instruction[LP_DRAM_ADDR_LSB +: LP_DRAM_ADDR_W];
    assign w_inst_bytes = ctrl_instruction[LP_BYTES_LSB +: LP_BYTES_W];
    assign w_inst_lines = ctrl_instruction[LP_LINES_LSB +: LP_LINES_W];
    assign w_inst_start = ctrl_instruction[LP_START_LSB +: C_BUF_ADDR_WIDTH];
    assign w_inst_group = ctrl_instruction[LP_GRP_LSB +: LP_GRP_W];
    assign w_unused_inst = ^{ctrl_instruction[LP_BYTES_LSB-1:LP_LINES_LSB+LP_LINES_W],
                             ctrl_instruction[LP_LINES_LSB-1:LP_START_LSB+C_BUF_ADDR_WIDTH],
                             ctrl_instruction[LP_START_LSB-1:LP_GRP_LSB+LP_GRP_W]};

    assign w_start_acc  = ap_start && (r_state == S_IDLE);
    assign w_beat_acc   = s_axis_tvalid && s_axis_tready;
    assign w_beat_write = w_beat_acc && (r_lines_left != '0);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        rd_ctrl_start = 1'b0;
        ap_done       = 1'b0;
        s_axis_tready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_state_nxt = (w_inst_bytes == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                rd_ctrl_start = 1'b1;
                w_state_nxt   = S_STREAM;
            end
            S_STREAM: begin
                s_axis_tready = 1'b1;
                // A beat accepted together with the done pulse is registered on
                // this edge and retires during FLUSH.
                if (r_rd_done || rd_ctrl_done) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                ap_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rd_addr    <= '0;
            r_xfer_size  <= '0;
            r_lines_left <= '0;
            r_cur_addr   <= '0;
            r_group      <= '0;
            r_rd_done    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
        end else begin
            r_wvalid <= w_beat_write;
            if (w_beat_write) begin
                r_waddr      <= r_cur_addr;
                r_wdata      <= s_axis_tdata;
                r_lines_left <= r_lines_left - 1'b1;
                if (r_cur_addr == C_BUF_ADDR_WIDTH'(LP_BUF_DEPTH - 1)) begin
                    r_cur_addr <= '0;
                end else begin
                    r_cur_addr <= r_cur_addr + 1'b1;
                end
            end
            if (rd_ctrl_done && ((r_state == S_ISSUE) || (r_state == S_STREAM))) begin
                r_rd_done <= 1'b1;
            end
            if (w_start_acc) begin
                r_rd_addr    <= C_M_AXI_ADDR_WIDTH'(w_inst_dram) + ctrl_addr_offset;
                r_xfer_size  <= C_XFER_SIZE_WIDTH'(w_inst_bytes);
                r_lines_left <= w_inst_lines;
                r_cur_addr   <= w_inst_start;
                r_group      <= w_inst_group;
                r_rd_done    <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_rd_addr    <= '0;
                r_xfer_size  <= '0;
                r_lines_left <= '0;
                r_cur_addr   <= '0;
                r_group      <= '0;
                r_rd_done    <= 1'b0;
            end
        end
    end

    assign rd_ctrl_addr_offset        = r_rd_addr;
    assign rd_ctrl_xfer_size_in_bytes = r_xfer_size;

`ifdef LOAD_LEN_CHECK_EN
    logic r_err_len;
    logic w_beat_drop;

    assign w_beat_drop = w_beat_acc && (r_lines_left == '0);

    // Overrun: a beat had no line left to fill. Underrun: finished with lines unwritten.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_err_len <= 1'b0;
        end else if (w_start_acc) begin
            r_err_len <= 1'b0;
        end else if (w_beat_drop || ((r_state == S_DONE) && (r_lines_left != '0))) begin
            r_err_len <= 1'b1;
        end
    end

    assign err_len_mismatch = r_err_len;
`endif

    load_group_demux #(
        .ADDR_W (C_BUF_ADDR_WIDTH),
        .DATA_W (C_M_AXI_DATA_WIDTH)
    ) u_demux (
        .i_wvalid    (r_wvalid),
        .i_waddr     (r_waddr),
        .i_wdata     (r_wdata),
        .i_group     (r_group),
        .o_wvalid_1a (load_write_buffer_1_A_wvalid),
        .o_waddr_1a  (load_write_buffer_1_A_waddr),
        .o_wdata_1a  (load_write_buffer_1_A_wdata),
        .o_wvalid_2a (load_write_buffer_2_A_wvalid),
        .o_waddr_2a  (load_write_buffer_2_A_waddr),
        .o_wdata_2a  (load_write_buffer_2_A_wdata),
        .o_wvalid_1b (load_write_buffer_1_B_wvalid),
        .o_waddr_1b  (load_write_buffer_1_B_waddr),
        .o_wdata_1b  (load_write_buffer_1_B_wdata),
        .o_wvalid_2b (load_write_buffer_2_B_wvalid),
        .o_waddr_2b  (load_write_buffer_2_B_waddr),
        .o_wdata_2b  (load_write_buffer_2_B_wdata)
    );

endmodule

// File: doc/load.md
# load

Upstream neighbour of `save` in the GNN kernel datapath.
- Decodes a 128-bit load instruction from the ctrl module and launches one transfer on the AXI read master (`gnn_0_example_axi_read_master`).
- Takes the returned AXI-stream beats and writes them, one 512-bit line per beat, into the one on-chip feature buffer selected by the instruction's group field (1_A, 2_A, 1_B, 2_B).
- Pulses `ap_done` once the read master reports done and the last line has been written.

## Interface
Parameters:
- LOAD_INST_LENGTH, 128, instruction width
- C_M_AXI_ADDR_WIDTH, 64, DRAM address width
- C_M_AXI_DATA_WIDTH, 512, stream and buffer line width
- C_XFER_SIZE_WIDTH, 32, read-master transfer-size width
- C_BUF_ADDR_WIDTH, 11, buffer line address width

Ports:
- aclk  in  1  clock; all logic on posedge
- areset  in  1  reset; **synchronous, active-high**
- ap_start  in  1  one-cycle start pulse from ctrl
- ap_done  out  1  one-cycle completion pulse
- ctrl_addr_offset  in  C_M_AXI_ADDR_WIDTH  DRAM base offset
- ctrl_instruction  in  LOAD_INST_LENGTH  instruction, sampled when ap_start is accepted
- rd_ctrl_start  out  1  one-cycle start pulse to the read master
- rd_ctrl_done  in  1  read master done pulse
- rd_ctrl_addr_offset  out  C_M_AXI_ADDR_WIDTH  DRAM start address
- rd_ctrl_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  transfer length in bytes
- s_axis_tvalid  in  1  stream beat valid
- s_axis_tready  out  1  stream beat ready
- s_axis_tdata  in  C_M_AXI_DATA_WIDTH  stream beat data
- load_write_buffer_{1_A,2_A,1_B,2_B}_wvalid  out  1  per-buffer line write enable
- load_write_buffer_{1_A,2_A,1_B,2_B}_waddr  out  C_BUF_ADDR_WIDTH  per-buffer line address
- load_write_buffer_{1_A,2_A,1_B,2_B}_wdata  out  C_M_AXI_DATA_WIDTH  per-buffer line data
- err_len_mismatch  out  1  present only with LOAD_LEN_CHECK_EN (see Configuration)

## Operation
Instruction fields:
- [127:96] DRAM address; `rd_ctrl_addr_offset` = field + `ctrl_addr_offset`, full 64-bit add.
- [95:80] byte count, zero-extended to C_XFER_SIZE_WIDTH.
- [63:48] line count.
- [47:32] buffer start line; the low 11 bits are used.
- [5:0] one-hot group: 000001 = 1_A, 000010 = 2_A, 000100 = 1_B, 001000 = 2_B.
  - Any other group value writes no buffer. Beats are still consumed and `ap_done` still fires.

FSM states: IDLE, ISSUE, STREAM, FLUSH, DONE.
- **IDLE:** on `ap_start`, latch all fields; `lines_left` = line count; `cur_addr` = start line.
  - If byte count == 0, go to DONE.
  - Otherwise go to ISSUE.
  - `ap_start` outside IDLE is ignored.
- **ISSUE:** `rd_ctrl_start` = 1 for exactly this cycle; next state STREAM.
- **STREAM:** `s_axis_tready` = 1 every cycle.
  - On each accepted beat with `lines_left` != 0: write the line at `cur_addr`; `cur_addr` +1, wrapping 2047 -> 0; `lines_left` -1.
  - Beats arriving with `lines_left` == 0 are accepted and discarded, so the read master can always drain.
  - `rd_ctrl_done` latches a sticky `rd_done` flag.
  - When `rd_done` is set (either already latched or arriving this cycle) and no write is pending, go to FLUSH.
- **FLUSH:** one cycle; lets the final registered write retire; next state DONE.
- **DONE:** `ap_done` = 1 for one cycle; clear the latched fields; return to IDLE.

Other rules:
- Unselected buffers hold `wvalid` = 0 at all times.
- The selected buffer's `waddr` and `wdata` are driven only while its `wvalid` = 1. They hold their last value otherwise.

## Timing
- Reset values: every output 0, FSM in IDLE. Reset mid-transfer abandons the transfer silently, with no `ap_done`.
- `ap_start` at cycle N -> `rd_ctrl_start` at N+1. Zero-byte instruction: `ap_done` at N+1.
- Beat accepted at cycle M -> buffer `wvalid`, `waddr`, `wdata` registered and visible at M+1. Throughput is one line per cycle, with no bubbles inserted.
- `rd_ctrl_done` arriving in the same cycle as the last beat: the beat is written at +1, FLUSH at +1, `ap_done` at +2.
- `rd_ctrl_addr_offset` and `rd_ctrl_xfer_size_in_bytes` are stable from ISSUE until DONE.

## Configuration
- **LOAD_LEN_CHECK_EN defined:**
  - Adds port `err_len_mismatch`.
  - Sticky flag, set when a beat is discarded (overrun), or when DONE is reached with `lines_left` != 0 (underrun).
  - Cleared by reset or by the next accepted `ap_start`.
- **LOAD_LEN_CHECK_EN undefined:** the port and its logic are absent; overrun beats are still discarded.

## Structure
- **load_pkg:**
  - State enum `load_state_t`.
  - Localparams for the instruction field bit positions.
  - Group one-hot codes `GRP_1A`, `GRP_2A`, `GRP_1B`, `GRP_2B`.
  - `LP_BUF_DEPTH` = 2048.
- **load_group_demux:** one sub-module. It takes the registered write (`wvalid`, `waddr`, `wdata`) plus the latched group and fans it out to the four buffer ports.

## Test plan
- **Normal load:** group 000100, start line 10, 4 lines, 256 B, stream 4 beats back-to-back.
  - 1_B `wvalid` high for 4 cycles at addresses 10–13 with matching data.
  - `ap_done` one cycle after FLUSH.
  - No other buffer's `wvalid` toggles.
- **Wrap-around:** start line 2046, 3 lines.
  - Write addresses 2046, 2047, 0.
- **Overrun:** 2 lines requested, 3 beats streamed.
  - 2 writes only; third beat accepted and discarded.
  - `err_len_mismatch` = 1 (with LOAD_LEN_CHECK_EN).
- **Zero bytes / bad group:**
  - Byte count 0: `ap_done` at N+1 and `rd_ctrl_start` never asserted.
  - Group 110000 with 4 beats: no writes, `ap_done` still pulses.
- **Reset and busy start:**
  - `areset` after 2 of 4 beats: all outputs 0 next cycle, no `ap_done`.
  - `ap_start` during STREAM is ignored.
